// File: rtl/toff_seq_ctrl.sv
// toff_seq_ctrl: gate-program sequencer for the reversible datapath.
// A small program store of NOP/NOT/CNOT/Toffoli entries is applied one
// gate per clock to a WIDTH-bit working register, in forward or reverse
// order, and the result is handed off with a valid/ready handshake.
module toff_seq_ctrl #(
  parameter int WIDTH      = 8,
  parameter int PROG_DEPTH = 16,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int AW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1,
  localparam int PW = 2 + 3*IW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [PW-1:0]    prog_data,
  input  logic [AW:0]      prog_len,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_NOT  = 2'd1;
  localparam logic [1:0] OP_CNOT = 2'd2;
  localparam logic [1:0] OP_TOFF = 2'd3;

  // Run length clamp value, sized to match prog_len.
  localparam logic [AW:0] DEPTH_LEN = (AW+1)'(PROG_DEPTH);

  state_t state, state_next;

  logic [PW-1:0]    prog_mem [PROG_DEPTH];
  logic [WIDTH-1:0] work_reg;
  logic [AW-1:0]    pc;
  logic [AW:0]      remaining;
  logic             dir_lat;
  logic             err_reg;

  logic             accept;
  logic [AW:0]      len_sat;
  logic [AW:0]      len_m1;

  logic [PW-1:0]    entry;
  logic [1:0]       op;
  logic [IW-1:0]    tgt, ca, cb;
  logic             tgt_bad, ca_bad, cb_bad;
  logic             illegal;
  logic             flip;
  logic [WIDTH-1:0] gate_mask;

  assign accept   = (state == IDLE) && start;
  assign len_sat  = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
  assign len_m1   = len_sat - 1'b1;
  assign data_out = work_reg;
  assign err      = err_reg;

  // Program store: no reset, writes blocked while a run is in flight.
  always_ff @(posedge clk) begin
    if (prog_we && !busy && (32'(prog_addr) < 32'(PROG_DEPTH)))
      prog_mem[prog_addr] <= prog_data;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (len_sat == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (remaining == (AW+1)'(1)) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Decode the current entry; an illegal entry degrades to a NOP.
  always_comb begin
    entry   = prog_mem[pc];
    op      = entry[PW-1 -: 2];
    tgt     = entry[3*IW-1 -: IW];
    ca      = entry[2*IW-1 -: IW];
    cb      = entry[IW-1:0];
    tgt_bad = 32'(tgt) >= 32'(WIDTH);
    ca_bad  = 32'(ca)  >= 32'(WIDTH);
    cb_bad  = 32'(cb)  >= 32'(WIDTH);
    illegal = 1'b0;
    flip    = 1'b0;
    case (op)
      OP_NOP: begin
        illegal = 1'b0;
        flip    = 1'b0;
      end
      OP_NOT: begin
        illegal = tgt_bad;
        flip    = 1'b1;
      end
      OP_CNOT: begin
        illegal = tgt_bad || ca_bad || (ca == tgt);
        flip    = ca_bad ? 1'b0 : work_reg[ca];
      end
      OP_TOFF: begin
        illegal = tgt_bad || ca_bad || cb_bad || (ca == tgt) || (cb == tgt);
        flip    = (ca_bad || cb_bad) ? 1'b0 : (work_reg[ca] & work_reg[cb]);
      end
      default: begin
        illegal = 1'b0;
        flip    = 1'b0;
      end
    endcase
  end

  // One-hot flip mask: only the target bit may toggle.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_mask
      assign gate_mask[gi] = flip && !illegal && (32'(tgt) == gi);
    end
  endgenerate

  // Working register, program counter, gate count and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_reg  <= '0;
      pc        <= '0;
      remaining <= '0;
      dir_lat   <= 1'b0;
      err_reg   <= 1'b0;
    end else if (accept) begin
      work_reg  <= data_in;
      pc        <= dir ? len_m1[AW-1:0] : '0;
      remaining <= len_sat;
      dir_lat   <= dir;
      err_reg   <= 1'b0;
    end else if (state == RUN) begin
      work_reg  <= work_reg ^ gate_mask;
      pc        <= dir_lat ? (pc - 1'b1) : (pc + 1'b1);
      remaining <= remaining - 1'b1;
      if (illegal) err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_toff_seq_ctrl.sv
// Self-checking bench for toff_seq_ctrl against a loop-based gate model.
module tb_toff_seq_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int PW    = 11;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             prog_we;
  logic [AW-1:0]    prog_addr;
  logic [PW-1:0]    prog_data;
  logic [AW:0]      prog_len;
  logic             start;
  logic             dir;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             err;

  int checks = 0;
  int errors = 0;

  int m_op [DEPTH];
  int m_tgt[DEPTH];
  int m_ca [DEPTH];
  int m_cb [DEPTH];

  always #5 clk = ~clk;

  toff_seq_ctrl #(.WIDTH(WIDTH), .PROG_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start), .dir(dir),
    .data_in(data_in), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .err(err)
  );

  // Gate legality from the rule list.
  function automatic bit is_bad(input int op, input int t, input int c, input int b);
    case (op)
      1: return t >= WIDTH;
      2: return t >= WIDTH || c >= WIDTH || c == t;
      3: return t >= WIDTH || c >= WIDTH || b >= WIDTH || c == t || b == t;
      default: return 1'b0;
    endcase
  endfunction

  // Reference: walk the program entries in the requested order.
  function automatic void model_run(input logic [7:0] din, input int len, input bit rev,
                                    output logic [7:0] r, output bit e);
    int n;
    int i;
    n = (len > DEPTH) ? DEPTH : len;
    r = din;
    e = 1'b0;
    for (int k = 0; k < n; k++) begin
      i = rev ? (n - 1 - k) : k;
      if (is_bad(m_op[i], m_tgt[i], m_ca[i], m_cb[i])) begin
        e = 1'b1;
      end else begin
        case (m_op[i])
          1: r[m_tgt[i]] = ~r[m_tgt[i]];
          2: r[m_tgt[i]] = r[m_tgt[i]] ^ r[m_ca[i]];
          3: r[m_tgt[i]] = r[m_tgt[i]] ^ (r[m_ca[i]] & r[m_cb[i]]);
          default: ;
        endcase
      end
    end
  endfunction

  task automatic write_entry(input int addr, input int op, input int t, input int c, input int b);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = addr[AW-1:0];
    prog_data = {op[1:0], t[2:0], c[2:0], b[2:0]};
    @(negedge clk);
    prog_we = 1'b0;
    m_op[addr] = op; m_tgt[addr] = t; m_ca[addr] = c; m_cb[addr] = b;
  endtask

  task automatic program_random(input bit legal_only);
    int op, t, c, b;
    for (int i = 0; i < DEPTH; i++) begin
      do begin
        op = $urandom_range(0, 3);
        t  = $urandom_range(0, 7);
        c  = $urandom_range(0, 7);
        b  = $urandom_range(0, 7);
      end while (legal_only && is_bad(op, t, c, b));
      write_entry(i, op, t, c, b);
    end
  endtask

  // Launch a run and wait (bounded) for out_valid; cycles counts edges
  // from the accepting edge up to the one that raised out_valid.
  task automatic do_run(input logic [7:0] din, input int len, input bit rev, output int cycles);
    @(negedge clk);
    start    = 1'b1;
    data_in  = din;
    prog_len = len[AW:0];
    dir      = rev;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    while (out_valid !== 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    $display("run din=%h len=%0d dir=%0d -> dout=%h err=%0d cycles=%0d",
             din, len, rev, data_out, err, cycles);
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    int cyc;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_out); end
    do_run(8'h5C, 0, 1'b0, cyc);
    checks++; if (data_out !== 8'h5C) begin errors++; $display("FAIL pre_async_data: got %h expected 5c", data_out); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b expected 0", out_valid); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL async_data: got %h expected 00", data_out); end
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL async_busy_err: got %b%b expected 00", busy, err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_toff;
    int cyc;
    write_entry(0, 3, 2, 0, 1);
    do_run(8'h03, 1, 1'b0, cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL toff_latency: got %0d expected 2", cyc); end
    checks++; if (data_out !== 8'h07) begin errors++; $display("FAIL toff_03: got %h expected 07", data_out); end
    consume;
    checks++; if (out_valid !== 1'b0 || data_out !== 8'h07) begin errors++; $display("FAIL toff_handoff: got %b/%h expected 0/07", out_valid, data_out); end
    do_run(8'h01, 1, 1'b0, cyc);
    checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL toff_01: got %h expected 01", data_out); end
    consume;
  endtask

  task automatic test_round_trip;
    int cyc;
    logic [7:0] x;
    bit e;
    write_entry(0, 1, 7, 0, 0);
    write_entry(1, 2, 1, 0, 0);
    write_entry(2, 3, 3, 1, 2);
    write_entry(3, 3, 0, 3, 7);
    model_run(8'hA5, 4, 1'b0, x, e);
    do_run(8'hA5, 4, 1'b0, cyc);
    checks++; if (data_out !== x) begin errors++; $display("FAIL rt_forward: got %h expected %h", data_out, x); end
    consume;
    do_run(x, 4, 1'b1, cyc);
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL rt_reverse: got %h expected a5", data_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rt_err: got %b expected 0", err); end
    consume;
  endtask

  task automatic test_len_edges;
    int cyc;
    logic [7:0] exp, din;
    bit e;
    do_run(8'h5C, 0, 1'b0, cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL len0_latency: got %0d expected 1", cyc); end
    checks++; if (data_out !== 8'h5C) begin errors++; $display("FAIL len0_data: got %h expected 5c", data_out); end
    consume;
    program_random(1'b1);
    din = 8'($urandom);
    model_run(din, DEPTH + 3, 1'b0, exp, e);
    do_run(din, DEPTH + 3, 1'b0, cyc);
    checks++; if (cyc !== DEPTH + 1) begin errors++; $display("FAIL sat_latency: got %0d expected %0d", cyc, DEPTH + 1); end
    checks++; if (data_out !== exp) begin errors++; $display("FAIL sat_data: got %h expected %h", data_out, exp); end
    consume;
  endtask

  task automatic test_backpressure;
    int cyc;
    logic [7:0] exp, din;
    bit e;
    din = 8'($urandom);
    model_run(din, 4, 1'b1, exp, e);
    do_run(din, 4, 1'b1, cyc);
    for (int k = 0; k < 5; k++) begin
      start   = 1'b1;
      data_in = ~din;
      prog_len = 5'd0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || data_out !== exp) begin errors++; $display("FAIL bp_hold%0d: got %b/%h expected 1/%h", k, out_valid, data_out, exp); end
    end
    start = 1'b0;
    consume;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || data_out !== exp) begin errors++; $display("FAIL bp_release: got %b%b/%h expected 00/%h", out_valid, busy, data_out, exp); end
  endtask

  task automatic test_protection;
    int cyc, alt;
    logic [7:0] exp, din, ra, rb;
    bit e;
    int so, st, sc, sb;
    din = 8'($urandom);
    model_run(din, DEPTH, 1'b0, exp, e);
    so = m_op[0]; st = m_tgt[0]; sc = m_ca[0]; sb = m_cb[0];
    alt = 0;
    for (int t = 0; t < 8; t++) begin
      m_op[0] = 1; m_tgt[0] = t;
      model_run(din, DEPTH, 1'b0, ra, e);
      if (ra !== exp && alt == 0) alt = t + 1;
    end
    m_op[0] = so; m_tgt[0] = st; m_ca[0] = sc; m_cb[0] = sb;
    @(negedge clk);
    start = 1'b1; data_in = din; prog_len = 5'(DEPTH); dir = 1'b0;
    @(negedge clk);
    start = 1'b0;
    prog_we = 1'b1; prog_addr = '0; prog_data = {2'd1, 3'(alt - 1), 6'd0};
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prot_busy: got %b expected 1", busy); end
    @(negedge clk);
    prog_we = 1'b0;
    cyc = 2;
    while (out_valid !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    checks++; if (data_out !== exp) begin errors++; $display("FAIL prot_run1: got %h expected %h", data_out, exp); end
    consume;
    do_run(din, DEPTH, 1'b0, cyc);
    rb = data_out;
    checks++; if (rb !== exp) begin errors++; $display("FAIL prot_rerun: got %h expected %h", rb, exp); end
    consume;
  endtask

  task automatic test_illegal;
    int cyc;
    logic [7:0] din;
    din = 8'($urandom);
    write_entry(0, 3, 1, 1, 0);
    do_run(din, 1, 1'b0, cyc);
    checks++; if (data_out !== din) begin errors++; $display("FAIL ill_toff_data: got %h expected %h", data_out, din); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_toff_err: got %b expected 1", err); end
    consume;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_sticky: got %b expected 1", err); end
    write_entry(1, 2, 4, 4, 0);
    do_run(din, 2, 1'b1, cyc);
    checks++; if (data_out !== din || err !== 1'b1) begin errors++; $display("FAIL ill_cnot: got %h/%b expected %h/1", data_out, err, din); end
    consume;
    do_run(din, 0, 1'b0, cyc);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ill_clear: got %b expected 0", err); end
    consume;
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    logic [7:0] exp, din;
    bit e;
    program_random(1'b1);
    din = 8'($urandom);
    @(negedge clk);
    start = 1'b1; data_in = din; prog_len = 5'(DEPTH); dir = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || data_out !== 8'h00) begin errors++; $display("FAIL mid_reset: got %b%b/%h expected 00/00", busy, out_valid, data_out); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_idle: got %b%b expected 00", busy, out_valid); end
    model_run(din, DEPTH, 1'b0, exp, e);
    do_run(din, DEPTH, 1'b0, cyc);
    checks++; if (data_out !== exp) begin errors++; $display("FAIL mid_rerun: got %h expected %h", data_out, exp); end
    consume;
  endtask

  task automatic test_random;
    int cyc, len, nsat;
    logic [7:0] exp, din;
    bit e, rev;
    for (int it = 0; it < 24; it++) begin
      if (it % 6 == 0) program_random(it % 12 == 0);
      din = 8'($urandom);
      len = $urandom_range(0, DEPTH + 4);
      rev = 1'($urandom);
      nsat = (len > DEPTH) ? DEPTH : len;
      model_run(din, len, rev, exp, e);
      do_run(din, len, rev, cyc);
      checks++; if (cyc !== nsat + 1) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", it, cyc, nsat + 1); end
      checks++; if (data_out !== exp) begin errors++; $display("FAIL rnd%0d_data: got %h expected %h", it, data_out, exp); end
      checks++; if (err !== e) begin errors++; $display("FAIL rnd%0d_err: got %b expected %b", it, err, e); end
      consume;
    end
  endtask

  initial begin
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    prog_len = '0; start = 1'b0; dir = 1'b0; data_in = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    for (int i = 0; i < DEPTH; i++) write_entry(i, 0, 0, 0, 0);
    test_single_toff;
    test_round_trip;
    test_len_edges;
    test_backpressure;
    test_protection;
    test_illegal;
    test_reset_mid_run;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
